dreg_wr_arbiter: RTL and testbench



---
 rtl/dreg_wr_arbiter.sv | 102 ++++++++++
 tb/tb_dreg_wr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dreg_wr_arbiter.sv
// Round-robin write arbiter sharing one dreg between N requesters.
// Each write takes three cycles: IDLE (pick winner, latch data), LOAD (drive dreg), ACK (grant pulse).
module dreg_wr_arbiter #(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int CW = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk50m,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           dreg_en,
  output logic           dreg_load,
  output logic [W-1:0]   dreg_d,
  output logic [IW-1:0]  owner,
  output logic [CW-1:0]  wr_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [W-1:0]       data_q, data_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0][W-1:0] wdata_a;
  logic [IW-1:0]      win;

  assign wdata_a = wdata;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    logic found;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        idx_d   = win;
        data_d  = wdata_a[win];
        state_d = LOAD;
      end
      LOAD: state_d = ACK;
      ACK: begin
        ptr_d   = (idx_q == IW'(N-1)) ? '0 : idx_q + IW'(1);
        owner_d = idx_q;
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode from the registered state only, so no req-to-gnt path exists.
  assign busy      = (state_q != IDLE);
  assign dreg_en   = (state_q == LOAD);
  assign dreg_load = (state_q == LOAD);
  assign gnt       = (state_q == ACK) ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign dreg_d    = data_q;
  assign owner     = owner_q;
  assign wr_cnt    = cnt_q;

endmodule

// File: tb/tb_dreg_wr_arbiter.sv
// Directed bench for dreg_wr_arbiter with a behavioural dreg hanging off its outputs.
module tb_dreg_wr_arbiter;
  localparam int W = 16, N = 4, CW = 8, IW = 2;

  logic           clk50m = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic           busy, dreg_en, dreg_load;
  logic [W-1:0]   dreg_d, q;
  logic [IW-1:0]  owner;
  logic [CW-1:0]  wr_cnt;

  int nvec = 0, nerr = 0, cyc = 0;
  int gq[$];
  int gcyc[$];

  always #10 clk50m = ~clk50m;

  dreg_wr_arbiter #(.W(W), .N(N), .CW(CW)) dut (
    .clk50m(clk50m), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .busy(busy),
    .dreg_en(dreg_en), .dreg_load(dreg_load), .dreg_d(dreg_d), .owner(owner), .wr_cnt(wr_cnt)
  );

  // Downstream dreg, reset with rst_n = ~rst.
  logic dreg_rst_n;
  assign dreg_rst_n = ~rst;
  always_ff @(posedge clk50m) begin
    if (!dreg_rst_n) q <= '0;
    else if (dreg_en && dreg_load) q <= dreg_d;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50m);
    #1;
    cyc++;
  endtask

  function automatic int enc(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Steps until n grants are seen; non-kept requesters drop req on their grant.
  task automatic run_grants(input int n, input logic [N-1:0] keep);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      step();
      if (gnt != '0) begin
        gq.push_back(enc(gnt));
        gcyc.push_back(cyc);
        got++;
        req = req & ~(gnt & ~keep);
      end
    end
    if (got < n) chk("grant_timeout", got, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; wdata = '0;
    // 1: reset held with all requests pending
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", {dreg_en, dreg_load}, 0);
    chk("rst_owner", owner, 0);
    chk("rst_cnt", wr_cnt, 0);
    chk("rst_q", q, 16'h0000);
    rst = 1'b0; req = '0;
    step();

    // 2: single write from requester 2
    wdata[2*W +: W] = 16'haa55; req = 4'b0100;
    step();
    chk("sw_en", {dreg_en, dreg_load}, 2'b11);
    chk("sw_d", dreg_d, 16'haa55);
    chk("sw_busy", busy, 1);
    chk("sw_gnt_early", gnt, 0);
    step();
    chk("sw_gnt", gnt, 4'b0100);
    chk("sw_q", q, 16'haa55);
    chk("sw_en_off", {dreg_en, dreg_load}, 0);
    req = '0;
    step();
    chk("sw_owner", owner, 2);
    chk("sw_cnt", wr_cnt, 1);
    chk("sw_idle", {busy, gnt}, 0);

    // 3: contention from all four, fresh ptr
    do_reset();
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 16'h1111 * (i + 1);
    req = 4'b1111;
    gq.delete(); gcyc.delete();
    run_grants(4, 4'b0000);
    step();
    if (gq.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("ct_order%0d", i), gq[i], i);
      for (int i = 1; i < 4; i++) chk($sformatf("ct_gap%0d", i), gcyc[i] - gcyc[i-1], 3);
    end
    chk("ct_q", q, 16'h4444);
    chk("ct_owner", owner, 3);
    chk("ct_cnt", wr_cnt, 4);

    // 4: fairness between 0 and 3 after a grant to 0
    do_reset();
    req = 4'b0001;
    gq.delete(); gcyc.delete();
    run_grants(1, 4'b0000);
    req = 4'b1001;
    gq.delete(); gcyc.delete();
    run_grants(4, 4'b1001);
    req = '0;
    if (gq.size() == 4) begin
      chk("fr_0", gq[0], 3);
      chk("fr_1", gq[1], 0);
      chk("fr_2", gq[2], 3);
      chk("fr_3", gq[3], 0);
    end
    step();

    // 5: reset during LOAD; prior write to 1 leaves ptr=2, owner=1
    do_reset();
    wdata[1*W +: W] = 16'h0bee; req = 4'b0010;
    run_grants(1, 4'b0000);
    step();
    chk("ab_pre_owner", owner, 1);
    wdata[0 +: W] = 16'h1234; req = 4'b0001;
    step();
    chk("ab_load", dreg_en, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_gnt", gnt, 0);
    chk("ab_busy", busy, 0);
    chk("ab_cnt", wr_cnt, 0);
    chk("ab_owner", owner, 0);
    chk("ab_q", q, 16'h0000);
    wdata[3*W +: W] = 16'h3333; req = 4'b1001;
    step();
    chk("ab_gnt2", gnt, 0);
    step();
    chk("ab_ptr", gnt, 4'b0001);
    req = '0;
    step();

    // 6: saturation of wr_cnt
    do_reset();
    for (int i = 1; i <= 260; i++) begin
      wdata[1*W +: W] = 16'(i); req = 4'b0010;
      run_grants(1, 4'b0000);
      step();
      if (i == 254) chk("sat_254", wr_cnt, 254);
      if (i == 255) chk("sat_255", wr_cnt, 255);
      if (i == 256) chk("sat_256", wr_cnt, 255);
    end
    chk("sat_260", wr_cnt, 255);
    chk("sat_q", q, 16'(260));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
